// File: rtl/pipo_pkg.sv
// Shared constants for the parallel/serial register datapath: FSM encoding and default word width.
package pipo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/word_hold_buf.sv
// Single-entry WIDTH-bit holding buffer. A write while full and reading is never issued.
module word_hold_buf #(
  parameter int unsigned WIDTH = pipo_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (wr_en) begin
      data_d = wr_data;
      full_d = 1'b1;
    end else if (rd_en) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign rd_data = data_q;
  assign full    = full_q;

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter with a one-word holding buffer for gap-free frames.
// serial_out/valid/last are registered; load_ready and busy decode flops only.
module piso_shift_tx #(
  parameter int unsigned WIDTH     = pipo_pkg::DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             serial_last,
  output logic             busy
);

  import pipo_pkg::*;

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, shreg_shifted;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;

  logic             accept;
  logic             at_last;
  logic             hold_wr, hold_rd, hold_full;
  logic [WIDTH-1:0] hold_data;

  word_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (hold_wr),
    .wr_data (parallel_in),
    .rd_en   (hold_rd),
    .rd_data (hold_data),
    .full    (hold_full)
  );

  assign accept  = load_valid && load_ready;
  assign at_last = (state_q == ST_SHIFT) && (cnt_q == CntLast);

  assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave SHIFT only when no word is waiting at the word boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (at_last && !hold_full && !accept) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: shift register, bit counter and buffer control.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    hold_wr = 1'b0;
    hold_rd = 1'b0;
    if (state_q == ST_IDLE) begin
      if (accept) begin
        shreg_d = parallel_in;
        cnt_d   = '0;
      end
    end else if (at_last) begin
      cnt_d = '0;
      if (hold_full) begin
        shreg_d = hold_data;
        hold_rd = 1'b1;
      end else if (accept) begin
        shreg_d = parallel_in;
      end else begin
        shreg_d = shreg_shifted;
      end
    end else begin
      shreg_d = shreg_shifted;
      cnt_d   = cnt_q + CntW'(1);
      hold_wr = accept;
    end
  end

  // Output logic: registered serial outputs follow the next-cycle state.
  always_comb begin
    out_d      = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
    valid_d    = (state_d == ST_SHIFT);
    last_d     = valid_d && (cnt_d == CntLast);
    load_ready = !hold_full;
    busy       = (state_q == ST_SHIFT) || hold_full;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign serial_out   = out_q;
  assign serial_valid = valid_q;
  assign serial_last  = last_q;

endmodule
